// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache between MEM stage
// and a multi-cycle block memory; misses stall the pipeline until refilled.
module dcache_controller #(
    parameter int LINES      = 16,
    parameter int BLOCK_BITS = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(BLOCK_BITS / 8);
    localparam int WRD_W = OFF_W - 2;
    localparam int TAG_W = 32 - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    state_e state_q, state_d;

    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WRD_W-1:0]      word;
    logic [WRD_W+4:0]      bit_off;
    logic [BLOCK_BITS-1:0] line;
    logic [31:0]           rd_word;
    logic                  hit;
    logic                  store_en;
    logic                  fill_en;
    logic [1:0]            unused_addr;

    assign idx         = cpu_addr_i[OFF_W +: IDX_W];
    assign tag         = cpu_addr_i[31 -: TAG_W];
    assign word        = cpu_addr_i[2 +: WRD_W];
    assign bit_off     = {word, 5'b00000};
    assign line        = data_q[idx];
    assign rd_word     = line[bit_off +: 32];
    assign hit         = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
    assign unused_addr = cpu_addr_i[1:0];

    always_comb begin
        state_d     = state_q;
        cpu_stall_o = 1'b0;
        cpu_data_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        store_en    = 1'b0;
        fill_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (cpu_we_i) store_en = 1'b1;
                        else          cpu_data_o = rd_word;
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[idx], idx, {OFF_W{1'b0}}};
                mem_data_o  = line;
                if (mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {tag, idx, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (store_en) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Arrays carry no reset; valid bits alone decide whether contents matter.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill_en) begin
                data_q[idx] <= mem_data_i;
                tag_q[idx]  <= tag;
            end else if (store_en) begin
                data_q[idx][bit_off +: 32] <= cpu_data_i;
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed accesses push expected
// load data and memory transactions; a monitor pops and compares them.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_controller dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .cpu_stall_o(cpu_stall_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] data;
    } mexp_t;

    mexp_t        mq[$];
    logic [31:0]  lq[$];
    logic [255:0] mem_model [logic [31:0]];
    int           total = 0;
    int           bad = 0;
    int           lat = 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mkblk(input logic [31:0] a);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[32*w +: 32] = 32'h1000_0000 + a + w;
        return b;
    endfunction

    function automatic logic [255:0] blk(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return mkblk(a);
    endfunction

    // Memory responder: acks the lat-th cycle of each request.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (mem_req_o) cnt++;
            else cnt = 0;
            if (mem_req_o && cnt >= lat) begin
                cnt = 0;
                mem_ack_i = 1'b1;
                if (mem_we_o) mem_model[mem_addr_o] = mem_data_o;
                else mem_data_i = blk(mem_addr_o);
            end
        end
    end

    // Monitor
    initial begin
        mexp_t m;
        logic [31:0] l;
        forever begin
            @(negedge clk_i);
            #2;
            if (cpu_stall_o) chk("data_zero_in_stall", {224'd0, cpu_data_o}, 256'd0);
            if (mem_req_o && mem_ack_i) begin
                if (mq.size() == 0) begin
                    chk("unexpected_mem_txn", {224'd0, mem_addr_o}, 256'hFFFF_FFFF);
                end else begin
                    m = mq.pop_front();
                    chk("mem_we", {255'd0, mem_we_o}, {255'd0, m.we});
                    chk("mem_addr", {224'd0, mem_addr_o}, {224'd0, m.addr});
                    if (m.we) chk("mem_wb_data", mem_data_o, m.data);
                end
            end
            if (!rst_i && cpu_req_i && !cpu_we_i && !cpu_stall_o) begin
                if (lq.size() == 0) begin
                    chk("unexpected_load", {224'd0, cpu_data_o}, 256'hFFFF_FFFF);
                end else begin
                    l = lq.pop_front();
                    chk("load_data", {224'd0, cpu_data_o}, {224'd0, l});
                end
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int stalls);
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = a;
        cpu_data_i = d;
        #2;
        stalls = 0;
        while (cpu_stall_o && stalls < 50) begin
            @(negedge clk_i);
            #2;
            stalls++;
        end
        if (stalls >= 50) chk("stall_timeout", {255'd0, cpu_stall_o}, 256'd0);
    endtask

    task automatic idle();
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    function automatic mexp_t mx(input logic we, input logic [31:0] a, input logic [255:0] d);
        mexp_t m;
        m.we = we;
        m.addr = a;
        m.data = d;
        return m;
    endfunction

    initial begin
        int s;
        logic [255:0] b;
        rst_i = 1'b1;
        cpu_req_i = 1'b0;
        cpu_we_i = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        chk("rst_stall", {255'd0, cpu_stall_o}, 256'd0);
        chk("rst_mem_req", {255'd0, mem_req_o}, 256'd0);
        chk("rst_mem_we", {255'd0, mem_we_o}, 256'd0);
        chk("rst_mem_addr", {224'd0, mem_addr_o}, 256'd0);
        chk("rst_mem_data", mem_data_o, 256'd0);
        chk("rst_cpu_data", {224'd0, cpu_data_o}, 256'd0);

        // Clean miss, ack on third ALLOCATE cycle
        lat = 3;
        mq.push_back(mx(1'b0, 32'h0000_0000, '0));
        lq.push_back(32'h1000_0001);
        access(1'b0, 32'h0000_0004, '0, s);
        chk("stall_clean_miss", 256'(s), 256'd4);

        lq.push_back(32'h1000_0007);
        access(1'b0, 32'h0000_001C, '0, s);
        chk("stall_hit", 256'(s), 256'd0);
        chk("hit_no_mem_req", {255'd0, mem_req_o}, 256'd0);

        access(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, s);
        chk("stall_store_hit", 256'(s), 256'd0);
        chk("store_data_zero", {224'd0, cpu_data_o}, 256'd0);
        lq.push_back(32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0008, '0, s);
        chk("stall_load_after_store", 256'(s), 256'd0);

        // Dirty eviction of index 0
        lat = 1;
        b = mkblk(32'h0000_0000);
        b[64 +: 32] = 32'hDEAD_BEEF;
        mq.push_back(mx(1'b1, 32'h0000_0000, b));
        mq.push_back(mx(1'b0, 32'h0000_0200, '0));
        lq.push_back(32'h1000_0200);
        access(1'b0, 32'h0000_0200, '0, s);
        chk("stall_dirty_miss", 256'(s), 256'd3);

        // Store miss on clean index 1
        lat = 2;
        mq.push_back(mx(1'b0, 32'h0000_0020, '0));
        access(1'b1, 32'h0000_0024, 32'hCAFE_F00D, s);
        chk("stall_store_miss", 256'(s), 256'd3);
        lq.push_back(32'hCAFE_F00D);
        access(1'b0, 32'h0000_0024, '0, s);
        chk("stall_store_miss_reload", 256'(s), 256'd0);

        lat = 1;
        b = mkblk(32'h0000_0020);
        b[32 +: 32] = 32'hCAFE_F00D;
        mq.push_back(mx(1'b1, 32'h0000_0020, b));
        mq.push_back(mx(1'b0, 32'h0000_0220, '0));
        lq.push_back(32'h1000_0221);
        access(1'b0, 32'h0000_0224, '0, s);
        chk("stall_evict_store_line", 256'(s), 256'd3);

        mq.push_back(mx(1'b0, 32'h0000_0020, '0));
        lq.push_back(32'hCAFE_F00D);
        access(1'b0, 32'h0000_0024, '0, s);
        chk("stall_refetch_written_back", 256'(s), 256'd2);

        // Reset aborts an in-flight ALLOCATE
        lat = 5;
        @(negedge clk_i);
        cpu_req_i = 1'b1;
        cpu_we_i = 1'b0;
        cpu_addr_i = 32'h0000_0400;
        #2;
        chk("abort_miss_stall", {255'd0, cpu_stall_o}, 256'd1);
        @(negedge clk_i);
        #2;
        chk("abort_alloc_req", {255'd0, mem_req_o}, 256'd1);
        chk("abort_alloc_we", {255'd0, mem_we_o}, 256'd0);
        chk("abort_alloc_addr", {224'd0, mem_addr_o}, {224'd0, 32'h0000_0400});
        @(negedge clk_i);
        rst_i = 1'b1;
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        chk("abort_req_dropped", {255'd0, mem_req_o}, 256'd0);
        chk("abort_stall_clear", {255'd0, cpu_stall_o}, 256'd0);

        lat = 1;
        mq.push_back(mx(1'b0, 32'h0000_0400, '0));
        lq.push_back(32'h1000_0400);
        access(1'b0, 32'h0000_0400, '0, s);
        chk("stall_reload_after_abort", 256'(s), 256'd2);

        mq.push_back(mx(1'b0, 32'h0000_0020, '0));
        lq.push_back(32'hCAFE_F00D);
        access(1'b0, 32'h0000_0024, '0, s);
        chk("stall_invalidated_line", 256'(s), 256'd2);

        idle();
        repeat (3) @(negedge clk_i);
        chk("mq_drained", 256'(mq.size()), 256'd0);
        chk("lq_drained", 256'(lq.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
